tpu_job_scheduler: RTL and testbench

TPU_JOB_SCHEDULER -- requirements
Module: tpu_job_scheduler

---
 rtl/tpu_job_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_tpu_job_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_job_scheduler.sv
// tpu_job_scheduler: shares one TPU between NREQ requesters. An owner is
// picked round-robin, the TPU is enabled for one cycle, A*(N+M) operand words
// are streamed from the owner into the TPU, then N*M result words are
// forwarded back tagged with the owner id.
// Optional feature: define TPU_SCHED_WATCHDOG_EN to abort a job that waits
// TIMEOUT cycles in WAIT without tpu_done.
//
// Handshake: an operand word moves on every cycle where tpu_valid and
// tpu_ready are both high (tpu_valid/in_ready are combinational passthroughs
// of the owner's in_valid and the TPU's tpu_ready); result words are
// announced by res_valid and are never stalled.
module tpu_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int A       = 4,
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int TIMEOUT = 1024,
  localparam int IDW    = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    in_valid,
  input  logic [NREQ*32-1:0] in_data,
  output logic [NREQ-1:0]    in_ready,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [NREQ-1:0]    job_err,
  output logic               res_valid,
  output logic [31:0]        res_data,
  output logic [IDW-1:0]     res_id,
  output logic               tpu_enable,
  output logic               tpu_valid,
  output logic [31:0]        tpu_data_in,
  input  logic               tpu_ready,
  input  logic               tpu_err,
  input  logic               tpu_done,
  input  logic [31:0]        tpu_data_out
);

  localparam logic [15:0] LOAD_LAST = 16'(A * (N + M) - 1);
  localparam logic [15:0] RES_LAST  = 16'(N * M - 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("tpu_job_scheduler: NREQ must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("tpu_job_scheduler: TIMEOUT must be positive");
  end

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [15:0]     load_cnt_q, load_cnt_d;
  logic [15:0]     res_cnt_q, res_cnt_d;
  logic [NREQ-1:0] job_err_q, job_err_d;

  logic [NREQ-1:0] owner_oh;
  logic [IDW-1:0]  pick;
  logic            found;
  logic [IDW-1:0]  nxt_ptr;
  logic            xfer;
  logic            abort;
  logic            wd_expired;
  logic [31:0]     in_word [NREQ];

  assign owner_oh = NREQ'(1) << owner_q;
  assign nxt_ptr  = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign xfer     = (state_q == LOAD) && tpu_valid && tpu_ready;

`ifdef TPU_SCHED_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;

  // Watchdog: counts cycles spent in WAIT, cleared everywhere else
  always_comb begin
    wd_d = (state_q == WAIT) ? wd_q + 32'd1 : 32'd0;
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end

  assign wd_expired = (state_q == WAIT) && (wd_q == 32'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // Split the packed operand bus into one word per requester
  always_comb begin
    for (int i = 0; i < NREQ; i++) in_word[i] = in_data[i*32 +: 32];
  end

  // Round-robin pick: first request at or above the pointer, else the lowest one
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) >= ptr_q)) begin
        pick  = IDW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        pick  = IDW'(i);
        found = 1'b1;
      end
    end
  end

  // Next-state logic; an abort (tpu_err or watchdog) overrides everything
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    load_cnt_d = load_cnt_q;
    res_cnt_d  = res_cnt_q;
    job_err_d  = '0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (tpu_err) abort = 1'b1;
        else         state_d = LOAD;
      end
      LOAD: begin
        if (tpu_err) abort = 1'b1;
        else if (xfer) begin
          if (load_cnt_q == LOAD_LAST) begin
            load_cnt_d = '0;
            state_d    = WAIT;
          end else begin
            load_cnt_d = load_cnt_q + 16'd1;
          end
        end
      end
      WAIT: begin
        if (tpu_err) abort = 1'b1;
        else if (tpu_done) begin
          if (RES_LAST == 16'd0) begin
            state_d = IDLE;
            ptr_d   = nxt_ptr;
          end else begin
            res_cnt_d = 16'd1;
            state_d   = DRAIN;
          end
        end else if (wd_expired) abort = 1'b1;
      end
      DRAIN: begin
        if (res_cnt_q == RES_LAST) begin
          res_cnt_d = '0;
          state_d   = IDLE;
          ptr_d     = nxt_ptr;
        end else begin
          res_cnt_d = res_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      ptr_d      = nxt_ptr;
      load_cnt_d = '0;
      res_cnt_d  = '0;
      job_err_d  = owner_oh;
    end
  end

  // State, pointer, owner, counters and error pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      load_cnt_q <= '0;
      res_cnt_q  <= '0;
      job_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      load_cnt_q <= load_cnt_d;
      res_cnt_q  <= res_cnt_d;
      job_err_q  <= job_err_d;
    end
  end

  // Outputs: operand path is a passthrough in LOAD, results pass through in WAIT/DRAIN
  always_comb begin
    busy        = (state_q != IDLE);
    gnt         = busy ? owner_oh : '0;
    job_err     = job_err_q;
    tpu_enable  = (state_q == GRANT);
    tpu_valid   = (state_q == LOAD) && in_valid[owner_q];
    tpu_data_in = (state_q == LOAD) ? in_word[owner_q] : 32'd0;
    in_ready    = ((state_q == LOAD) && tpu_ready) ? owner_oh : '0;
    res_valid   = (state_q == DRAIN) || ((state_q == WAIT) && tpu_done && !tpu_err);
    res_data    = res_valid ? tpu_data_out : 32'd0;
    res_id      = res_valid ? owner_q : '0;
  end

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// tb_tpu_job_scheduler: directed plus randomized jobs against a round-robin
// reference model; result words, error pulses and grants are checked by an
// independent monitor that pops expectations from queues.
module tb_tpu_job_scheduler;

  localparam int NREQ     = 2;
  localparam int IDW      = 1;
  localparam int TA       = 4;
  localparam int TM       = 4;
  localparam int TN       = 4;
  localparam int TB_TMO   = 20;
  localparam int LOADN    = TA * (TN + TM);
  localparam int RESN     = TN * TM;
  localparam int ERR_WAIT = 1000;
  localparam int ERR_WD   = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NREQ-1:0]    req, in_valid, in_ready, gnt, job_err;
  logic [NREQ*32-1:0] in_data;
  logic               busy, res_valid, tpu_enable, tpu_valid;
  logic [31:0]        res_data, tpu_data_in, tpu_data_out;
  logic [IDW-1:0]     res_id;
  logic               tpu_ready, tpu_err, tpu_done;

  tpu_job_scheduler #(.NREQ(NREQ), .A(TA), .M(TM), .N(TN), .TIMEOUT(TB_TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .gnt(gnt), .busy(busy), .job_err(job_err),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .tpu_enable(tpu_enable), .tpu_valid(tpu_valid), .tpu_data_in(tpu_data_in),
    .tpu_ready(tpu_ready), .tpu_err(tpu_err), .tpu_done(tpu_done),
    .tpu_data_out(tpu_data_out)
  );

  // ---------------- scoreboard state ----------------
  logic [IDW+31:0] exp_q[$];
  logic [NREQ-1:0] err_q[$];
  logic [NREQ-1:0] gnt_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event that was not expected", name);
  endtask

  // Reference arbiter: first requester at or after the pointer, modulo NREQ
  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  // ---------------- driver ----------------
  // Starts and finishes at 1 time unit after a rising edge of an IDLE cycle.
  task automatic run_job(input logic [NREQ-1:0] reqv, input bit hold, input bit bp,
                         input int err_at, input int done_dly, input int rst_at);
    int o, nx, cyc;
    logic [NREQ-1:0] oh;
    bit rdy, vld, aborted;
    logic [31:0] w, d;
    req = reqv;
    o   = rr_pick(ptr_m, reqv);
    oh  = NREQ'(1) << o;
    gnt_q.push_back(oh);
    @(negedge clk);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    if (!hold) req = '0;
    @(negedge clk);
    check("grant_en", tpu_enable, 1);
    check("grant_ready", in_ready, 0);
    @(posedge clk); #1;
    nx = 0; cyc = 0; aborted = 1'b0; rdy = 1'b0;
    while (nx < LOADN && !aborted) begin
      if (cyc >= 400) begin
        fail_line("load_budget");
        return;
      end
      vld = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = bp ? !rdy : 1'b1;
      for (int s = 0; s < NREQ; s++) in_data[s*32 +: 32] = $urandom;
      in_valid    = NREQ'($urandom);
      in_valid[o] = vld;
      w           = in_data[o*32 +: 32];
      tpu_ready   = rdy;
      tpu_err     = (nx == err_at);
      @(negedge clk);
      check("load_valid", tpu_valid, vld);
      check("load_ready", in_ready, rdy ? oh : '0);
      check("load_en", tpu_enable, 0);
      if (vld) check("load_data", tpu_data_in, w);
      if (tpu_err) begin
        err_q.push_back(oh);
        aborted = 1'b1;
      end else if (vld && rdy) nx++;
      @(posedge clk); #1;
      tpu_err = 1'b0;
      cyc++;
    end
    in_valid  = '0;
    tpu_ready = 1'b1;
    ptr_m     = (o + 1) % NREQ;
    if (aborted) return;
`ifdef TPU_SCHED_WATCHDOG_EN
    if (err_at == ERR_WD) begin
      err_q.push_back(oh);
      for (int k = 0; k < TB_TMO; k++) begin
        @(negedge clk);
        check("wd_busy", busy, 1);
        @(posedge clk); #1;
      end
      return;
    end
`endif
    for (int k = 0; k < done_dly; k++) begin
      @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_ready", in_ready, 0);
      check("wait_res", res_valid, 0);
      @(posedge clk); #1;
    end
    if (err_at == ERR_WAIT) begin
      tpu_err = 1'b1; tpu_done = 1'b1; tpu_data_out = $urandom;
      err_q.push_back(oh);
      @(negedge clk);
      check("errdone_res", res_valid, 0);
      @(posedge clk); #1;
      tpu_err = 1'b0; tpu_done = 1'b0;
      return;
    end
    for (int k = 0; k < RESN; k++) begin
      d = $urandom;
      tpu_done     = (k == 0);
      tpu_data_out = d;
      exp_q.push_back({IDW'(o), d});
      if (k == rst_at) rst = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      tpu_done = 1'b0;
      if (k == rst_at) begin
        rst   = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_res", res_valid, 0);
        check("rst_err", job_err, 0);
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [NREQ-1:0] held;
    logic [IDW+31:0] e;
    bit prev_busy;
    held = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy === 1'b1 && !prev_busy) begin
          if (gnt_q.size() == 0) fail_line("gnt_unexpected");
          else check("gnt_owner", gnt, gnt_q.pop_front());
          held = gnt;
        end else if (busy === 1'b1) check("gnt_stable", gnt, held);
        else check("gnt_idle", gnt, 0);
        prev_busy = (busy === 1'b1);
        if (res_valid === 1'b1) begin
          if (exp_q.size() == 0) fail_line("res_unexpected");
          else begin
            e = exp_q.pop_front();
            check("res_word", {res_id, res_data}, e);
          end
        end
        if (job_err !== '0) begin
          if (err_q.size() == 0) fail_line("job_err_unexpected");
          else check("job_err", job_err, err_q.pop_front());
        end
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #400000;
    n_fail++;
    $display("FAIL global_timeout: run still active at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ea;
    rst = 1'b0; req = '0; in_valid = '0; in_data = '0;
    tpu_ready = 1'b0; tpu_err = 1'b0; tpu_done = 1'b0; tpu_data_out = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy0", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_tpu_enable", tpu_enable, 0);
    check("rst_tpu_valid", tpu_valid, 0);
    check("rst_tpu_data_in", tpu_data_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_job_err", job_err, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    tpu_ready = 1'b1;

    run_job(2'b01, 0, 0, -1, 5, -1);        // single job, owner 0
    run_job(2'b10, 0, 0, -1, 2, -1);        // owner 1, pointer back to 0
    run_job(2'b11, 1, 0, -1, 3, -1);        // contention: owner 0
    run_job(2'b11, 1, 0, -1, 0, -1);        // contention: owner 1
    run_job(2'b01, 0, 1, -1, 4, -1);        // backpressure on the TPU side
    run_job(2'b10, 0, 0, -1, 1, -1);
    run_job(2'b11, 1, 0, 10, 0, -1);        // error at load word 10, owner 0
    run_job(2'b11, 0, 0, -1, 2, -1);        // next grant goes to requester 1
    run_job(2'b01, 0, 0, ERR_WAIT, 3, -1);  // err and done together
    run_job(2'b01, 0, 0, -1, 1, 7);         // reset at result word 7
`ifdef TPU_SCHED_WATCHDOG_EN
    run_job(2'b01, 0, 0, ERR_WD, 0, -1);
`else
    run_job(2'b01, 0, 0, -1, 100, -1);      // long wait is never aborted
`endif

    for (int j = 0; j < 20; j++) begin
      case ($urandom_range(0, 9))
        0:       ea = $urandom_range(0, LOADN - 1);
        1:       ea = ERR_WAIT;
        default: ea = -1;
      endcase
      run_job(NREQ'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ea, $urandom_range(0, 8), -1);
    end

    req = '0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("res_queue_empty", exp_q.size(), 0);
    check("err_queue_empty", err_q.size(), 0);
    check("gnt_queue_empty", gnt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
